rvfi_trace_buffer: RTL and testbench
====================================

Name: rvfi_trace_buffer

Overview:
- Synthesisable, parametrised RVFI retire/trap recorder for NR_COMMIT_PORTS commit ports.
- Compacts each cycle's retire/trap records in port order, stamps them with a cycle count, and stores them in a DEPTH-entry circular buffer.
- Buffer is read out over a valid/ready stream.
- Sits beside the core in the testbench/FPGA harness. Replaces file-based tracing where $fwrite is unavailable, with a cycle window, stop-on-full or wrap mode, and retire/trap/drop counters.

Parameters:
- NR_COMMIT_PORTS, 2, number of RVFI commit ports (1..4).
- XLEN, 64, width of pc and rd_wdata.
- DEPTH, 64, buffer entries; power of two, at least 4.
- PW, max(1,$clog2(NR_COMMIT_PORTS)), derived, port-index field width.
- ENTRY_W, 1+PW+2+32+32+5+2*XLEN, derived, record width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- arm_i  in  1  single-cycle pulse: clear buffer and all counters, enter ARMED.
- start_cycle_i  in  32  first cycle of capture window, inclusive.
- stop_cycle_i  in  32  end of capture window, exclusive.
- wrap_en_i  in  1  1 = overwrite oldest entry when full; 0 = stop when full.
- valid_i  in  NR_COMMIT_PORTS  per-port retire valid.
- trap_i  in  NR_COMMIT_PORTS  per-port trap taken.
- mode_i  in  2*NR_COMMIT_PORTS  per-port privilege mode.
- pc_i  in  XLEN*NR_COMMIT_PORTS  per-port pc.
- insn_i  in  32*NR_COMMIT_PORTS  per-port instruction word.
- rd_addr_i  in  5*NR_COMMIT_PORTS  per-port destination register.
- rd_wdata_i  in  XLEN*NR_COMMIT_PORTS  per-port write data.
- rd_valid_o  out  1  buffer non-empty.
- rd_ready_i  in  1  consumer pops the head entry when rd_valid_o && rd_ready_i.
- rd_data_o  out  ENTRY_W  head entry. First-word fall-through; zero when empty.
- count_o  out  $clog2(DEPTH)+1  number of stored entries.
- state_o  out  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 FROZEN.
- instret_o  out  64  retires seen inside the window.
- trap_cnt_o  out  32  traps seen inside the window.
- dropped_cnt_o  out  32  records discarded or overwritten.

Behaviour:
- Reset (async, any time, including mid-capture):
  - state IDLE; cycle counter, pointers, count_o and all counters 0.
  - rd_valid_o = 0, rd_data_o = 0.
  - Memory contents don't-care.
- Cycle counter (32-bit):
  - Increments every cycle while state is not IDLE; wraps at 2^32.
  - Cleared by arm_i.
- Record per port p:
  - valid_i[p] gives kind 0 (retire). Otherwise trap_i[p] gives kind 1 (trap). Neither gives no record.
  - valid_i has priority over trap_i.
  - Field order MSB to LSB: kind, port idx, mode, cycle, pc, insn, rd_addr, rd_wdata.
- Window: records presented in cycle c are eligible iff state is ARMED or CAPTURE and start_cycle_i <= c < stop_cycle_i.
- FSM transitions:
  - IDLE to ARMED on arm_i.
  - ARMED to CAPTURE at the end of cycle == start_cycle_i.
  - CAPTURE to FROZEN at the end of cycle == stop_cycle_i-1, or on overflow in stop mode.
  - If stop_cycle_i <= start_cycle_i: ARMED goes to FROZEN at the end of cycle start_cycle_i and nothing is written.
  - arm_i from any state clears everything and enters ARMED. Records in the arm_i cycle are ignored.
  - FROZEN stays until arm_i or reset. Readout continues in FROZEN.
- Writes:
  - Eligible records are compacted in ascending port order and written in the same edge.
  - Latency 1: visible on count_o and rd_valid_o the next cycle.
- Space:
  - free = DEPTH - count + (pop this cycle). Simultaneous pop and push is legal.
- Stop mode (wrap_en_i = 0):
  - The first `free` records are written; the rest are dropped and added to dropped_cnt_o.
  - Any drop moves the FSM to FROZEN.
- Wrap mode (wrap_en_i = 1):
  - All records are written.
  - Excess over `free` advances the read pointer by the excess and adds the excess to dropped_cnt_o.
  - count_o saturates at DEPTH.
- Counters:
  - instret_o and trap_cnt_o count all eligible records, including dropped ones.
  - Counters saturate at all-ones.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: RVFI_TRACE_FREEZE_ON_TRAP_EN.
- Defined:
  - An eligible trap record is written, then the FSM goes to FROZEN at that edge.
  - Eligible records from higher-numbered ports in the same cycle are dropped and counted in dropped_cnt_o.
  - They are not counted in instret_o or trap_cnt_o.
- Undefined: traps are recorded like any other record and capture continues.

Test Plan:
- NR=2, DEPTH=8, start=0, stop=100, arm, then 3 cycles of dual retire -> count_o=6; pop order is port0 then port1 per cycle; cycle fields are 0,0,1,1,2,2; instret_o=6.
- Stop mode, 5 cycles of dual retire -> count_o=8, dropped_cnt_o=2, state_o=3. Separately, at count=8 with rd_ready_i=1 and one push -> count_o stays 8, no drop.
- Wrap mode, 6 cycles of dual retire, no pops -> count_o=8, dropped_cnt_o=4, first popped entry has cycle field 2 and port 0.
- start=10, stop=12, retire every cycle on port0 -> exactly 2 entries with cycle fields 10 and 11; state_o=3 from cycle 12.
- Assert rst_i mid-capture with count_o=5 -> same cycle: rd_valid_o=0, count_o=0, state_o=0, all counters 0.
- Macro defined: cycle 3 with port0 trap and port1 retire -> trap entry stored, port1 dropped, dropped_cnt_o=1, trap_cnt_o=1, state_o=3.

Source files
------------

// File: rtl/rvfi_trace_buffer.sv
// RVFI retire/trap recorder: compacted, cycle-stamped records in a circular buffer.
// Optional macro RVFI_TRACE_FREEZE_ON_TRAP_EN freezes capture after the first trap.
module rvfi_trace_buffer #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int XLEN = 64,
  parameter int DEPTH = 64,
  localparam int PW = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1,
  localparam int ENTRY_W = 1 + PW + 2 + 32 + 32 + 5 + 2 * XLEN,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            arm_i,
  input  logic [31:0]                     start_cycle_i,
  input  logic [31:0]                     stop_cycle_i,
  input  logic                            wrap_en_i,
  input  logic [NR_COMMIT_PORTS-1:0]      valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]      trap_i,
  input  logic [2*NR_COMMIT_PORTS-1:0]    mode_i,
  input  logic [XLEN*NR_COMMIT_PORTS-1:0] pc_i,
  input  logic [32*NR_COMMIT_PORTS-1:0]   insn_i,
  input  logic [5*NR_COMMIT_PORTS-1:0]    rd_addr_i,
  input  logic [XLEN*NR_COMMIT_PORTS-1:0] rd_wdata_i,
  output logic                            rd_valid_o,
  input  logic                            rd_ready_i,
  output logic [ENTRY_W-1:0]              rd_data_o,
  output logic [CW-1:0]                   count_o,
  output logic [1:0]                      state_o,
  output logic [63:0]                     instret_o,
  output logic [31:0]                     trap_cnt_o,
  output logic [31:0]                     dropped_cnt_o
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_FROZEN  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [31:0]        cyc_q;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [63:0]        instret_q;
  logic [31:0]        trap_q, drop_q;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [ENTRY_W-1:0]         rec [NR_COMMIT_PORTS];
  logic [CW-1:0]              slot [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] keep;
  logic [CW-1:0] n, ret_n, trap_n, cut_n;
  logic [CW-1:0] free, n_wr, excess, drop_sp, pop_w;
  logic          trap_frz, win, pop, freeze_ev;

  function automatic logic [63:0] sat64(logic [63:0] a, logic [CW-1:0] b);
    logic [64:0] s;
    s = {1'b0, a} + 65'(b);
    return s[64] ? '1 : s[63:0];
  endfunction

  function automatic logic [31:0] sat32(logic [31:0] a, logic [CW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

  assign win = (state_q == S_ARMED || state_q == S_CAPTURE) && !arm_i
               && (start_cycle_i <= cyc_q) && (cyc_q < stop_cycle_i);
  assign pop = rd_valid_o && rd_ready_i;
  assign pop_w = {{(CW-1){1'b0}}, pop};

  always_comb begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      rec[p] = {~valid_i[p], PW'(p), mode_i[2*p+:2], cyc_q,
                pc_i[XLEN*p+:XLEN], insn_i[32*p+:32],
                rd_addr_i[5*p+:5], rd_wdata_i[XLEN*p+:XLEN]};
    end
  end

  // Compact eligible records into consecutive slots in port order.
  always_comb begin
    n = '0;
    ret_n = '0;
    trap_n = '0;
    cut_n = '0;
    trap_frz = 1'b0;
    keep = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) slot[p] = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (win && (valid_i[p] || trap_i[p])) begin
        if (trap_frz) begin
          cut_n = cut_n + CW'(1);
        end else begin
          keep[p] = 1'b1;
          slot[p] = n;
          n = n + CW'(1);
          if (valid_i[p]) ret_n = ret_n + CW'(1);
          else trap_n = trap_n + CW'(1);
`ifdef RVFI_TRACE_FREEZE_ON_TRAP_EN
          if (!valid_i[p]) trap_frz = 1'b1;
`else
          trap_frz = 1'b0;
`endif
        end
      end
    end
  end

  always_comb begin
    free = DEPTH_C - count_q + pop_w;
    n_wr = n;
    excess = '0;
    drop_sp = '0;
    if (wrap_en_i) begin
      if (n > free) excess = n - free;
    end else if (n > free) begin
      n_wr = free;
      drop_sp = n - free;
    end
    freeze_ev = (drop_sp != '0) || trap_frz;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARMED: begin
        if (cyc_q == start_cycle_i) begin
          if (stop_cycle_i <= start_cycle_i || freeze_ev
              || cyc_q == stop_cycle_i - 32'd1)
            state_d = S_FROZEN;
          else
            state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (freeze_ev || cyc_q == stop_cycle_i - 32'd1)
          state_d = S_FROZEN;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cyc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      instret_q <= '0;
      trap_q <= '0;
      drop_q <= '0;
    end else if (arm_i) begin
      state_q <= S_ARMED;
      cyc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      instret_q <= '0;
      trap_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_IDLE) cyc_q <= cyc_q + 32'd1;
      wr_ptr_q <= wr_ptr_q + AW'(n_wr);
      rd_ptr_q <= rd_ptr_q + AW'(excess + pop_w);
      count_q <= count_q - pop_w + n_wr - excess;
      instret_q <= sat64(instret_q, ret_n);
      trap_q <= sat32(trap_q, trap_n);
      drop_q <= sat32(drop_q, drop_sp + excess + cut_n);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (keep[p] && slot[p] < n_wr)
        mem[wr_ptr_q + AW'(slot[p])] <= rec[p];
    end
  end

  assign rd_valid_o = (count_q != '0);
  assign rd_data_o = rd_valid_o ? mem[rd_ptr_q] : '0;
  assign count_o = count_q;
  assign state_o = state_q;
  assign instret_o = instret_q;
  assign trap_cnt_o = trap_q;
  assign dropped_cnt_o = drop_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Scoreboard bench for rvfi_trace_buffer: NR=2, XLEN=64, DEPTH=8.
// Expected records are queued at stimulus time; a monitor checks every pop.
module tb_rvfi_trace_buffer;
  localparam int NR = 2;
  localparam int XL = 64;
  localparam int DP = 8;
  localparam int PW = 1;
  localparam int EW = 1 + PW + 2 + 32 + 32 + 5 + 2 * XL;
  localparam int CW = $clog2(DP) + 1;

  logic          clk, rst, arm;
  logic [31:0]   start_c, stop_c;
  logic          wrap;
  logic [NR-1:0] valid, trap;
  logic [2*NR-1:0] mode;
  logic [XL*NR-1:0] pc, wdata;
  logic [32*NR-1:0] insn;
  logic [5*NR-1:0] rd_addr;
  logic          rd_valid, rd_ready;
  logic [EW-1:0] rd_data;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [63:0]   instret;
  logic [31:0]   trap_cnt, dropped;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  rvfi_trace_buffer #(.NR_COMMIT_PORTS(NR), .XLEN(XL), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm),
    .start_cycle_i(start_c), .stop_cycle_i(stop_c), .wrap_en_i(wrap),
    .valid_i(valid), .trap_i(trap), .mode_i(mode), .pc_i(pc),
    .insn_i(insn), .rd_addr_i(rd_addr), .rd_wdata_i(wdata),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .count_o(count), .state_o(state), .instret_o(instret),
    .trap_cnt_o(trap_cnt), .dropped_cnt_o(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XL-1:0] f_pc(int p, int c);
    return 64'h8000_0000 + 64'(c * 8 + p * 4);
  endfunction
  function automatic logic [31:0] f_insn(int p, int c);
    return 32'h13 + 32'(c * 256 + p);
  endfunction
  function automatic logic [4:0] f_rd(int p, int c);
    return 5'(c + p + 1);
  endfunction
  function automatic logic [XL-1:0] f_wd(int p, int c);
    return {32'hdead_0000 + 32'(p), 32'(c)};
  endfunction
  function automatic logic [1:0] f_md(int p);
    return (p == 0) ? 2'b11 : 2'b01;
  endfunction

  function automatic logic [EW-1:0] rec(bit k, int p, int c);
    return {k, PW'(p), f_md(p), 32'(c), f_pc(p, c), f_insn(p, c),
            f_rd(p, c), f_wd(p, c)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chk_rec(input logic [EW-1:0] a, input logic [EW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL pop_data: got %h expected %h", a, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h expected no entry", rd_data);
      end else begin
        chk_rec(rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0;
    trap = '0;
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] t, input int c);
    for (int p = 0; p < NR; p++) begin
      pc[XL*p+:XL] = f_pc(p, c);
      insn[32*p+:32] = f_insn(p, c);
      rd_addr[5*p+:5] = f_rd(p, c);
      wdata[XL*p+:XL] = f_wd(p, c);
    end
    valid = v;
    trap = t;
    tick();
  endtask

  task automatic do_arm(input int s, input int e, input bit w);
    start_c = 32'(s);
    stop_c = 32'(e);
    wrap = w;
    idle();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain();
    idle();
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && rd_valid; i++) tick();
    rd_ready = 1'b0;
    chk("drain_empty", 64'(rd_valid), 64'd0);
    chk("drain_leftover", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    rd_ready = 1'b0;
    start_c = '0;
    stop_c = '0;
    wrap = 1'b0;
    mode = {2'b01, 2'b11};
    pc = '0;
    insn = '0;
    rd_addr = '0;
    wdata = '0;
    idle();
    repeat (3) tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(|rd_data), 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_hold", 64'(state), 64'd0);

    // dual retire, pop order and cycle stamps
    do_arm(0, 100, 1'b0);
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(rec(1'b0, 0, c));
      exp_q.push_back(rec(1'b0, 1, c));
      step(2'b11, 2'b00, c);
    end
    idle();
    chk("basic_count", 64'(count), 64'd6);
    chk("basic_instret", instret, 64'd6);
    chk("basic_state", 64'(state), 64'd2);
    drain();

    // stop mode overflow
    do_arm(0, 100, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        exp_q.push_back(rec(1'b0, 0, c));
        exp_q.push_back(rec(1'b0, 1, c));
      end
      step(2'b11, 2'b00, c);
    end
    idle();
    chk("stop_count", 64'(count), 64'd8);
    chk("stop_dropped", 64'(dropped), 64'd2);
    chk("stop_state", 64'(state), 64'd3);
    chk("stop_instret", instret, 64'd10);
    drain();
    chk("frozen_hold", 64'(state), 64'd3);

    // full buffer with simultaneous pop and push
    do_arm(0, 100, 1'b0);
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(rec(1'b0, 0, c));
      exp_q.push_back(rec(1'b0, 1, c));
      step(2'b11, 2'b00, c);
    end
    exp_q.push_back(rec(1'b0, 0, 4));
    rd_ready = 1'b1;
    step(2'b01, 2'b00, 4);
    rd_ready = 1'b0;
    idle();
    chk("poppush_count", 64'(count), 64'd8);
    chk("poppush_dropped", 64'(dropped), 64'd0);
    chk("poppush_state", 64'(state), 64'd2);
    drain();

    // wrap mode overwrite
    do_arm(0, 100, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        exp_q.push_back(rec(1'b0, 0, c));
        exp_q.push_back(rec(1'b0, 1, c));
      end
      step(2'b11, 2'b00, c);
    end
    idle();
    chk("wrap_count", 64'(count), 64'd8);
    chk("wrap_dropped", 64'(dropped), 64'd4);
    chk("wrap_state", 64'(state), 64'd2);
    chk("wrap_instret", instret, 64'd12);
    drain();

    // capture window [10,12)
    do_arm(10, 12, 1'b0);
    for (int c = 0; c < 14; c++) begin
      if (c == 10 || c == 11) exp_q.push_back(rec(1'b0, 0, c));
      step(2'b01, 2'b00, c);
      if (c == 9) chk("win_armed", 64'(state), 64'd1);
      if (c == 10) chk("win_capture", 64'(state), 64'd2);
      if (c == 11) chk("win_frozen", 64'(state), 64'd3);
    end
    idle();
    chk("win_count", 64'(count), 64'd2);
    chk("win_instret", instret, 64'd2);
    drain();

    // empty window: stop <= start
    do_arm(5, 5, 1'b0);
    for (int c = 0; c < 7; c++) begin
      step(2'b01, 2'b00, c);
      if (c == 4) chk("empty_armed", 64'(state), 64'd1);
    end
    idle();
    chk("empty_state", 64'(state), 64'd3);
    chk("empty_count", 64'(count), 64'd0);
    chk("empty_instret", instret, 64'd0);

    // traps, valid priority and compaction
`ifdef RVFI_TRACE_FREEZE_ON_TRAP_EN
    do_arm(0, 100, 1'b0);
    for (int c = 0; c < 3; c++) step(2'b00, 2'b00, c);
    exp_q.push_back(rec(1'b1, 0, 3));
    step(2'b10, 2'b01, 3);
    idle();
    chk("frz_count", 64'(count), 64'd1);
    chk("frz_dropped", 64'(dropped), 64'd1);
    chk("frz_trap", 64'(trap_cnt), 64'd1);
    chk("frz_instret", instret, 64'd0);
    chk("frz_state", 64'(state), 64'd3);
`else
    do_arm(0, 100, 1'b0);
    exp_q.push_back(rec(1'b1, 0, 0));
    exp_q.push_back(rec(1'b0, 1, 0));
    step(2'b10, 2'b01, 0);
    exp_q.push_back(rec(1'b0, 0, 1));
    exp_q.push_back(rec(1'b1, 1, 1));
    step(2'b01, 2'b11, 1);
    exp_q.push_back(rec(1'b0, 1, 2));
    step(2'b10, 2'b00, 2);
    idle();
    chk("trap_count", 64'(count), 64'd5);
    chk("trap_cnt", 64'(trap_cnt), 64'd2);
    chk("trap_instret", instret, 64'd3);
    chk("trap_dropped", 64'(dropped), 64'd0);
    chk("trap_state", 64'(state), 64'd2);
`endif
    drain();

    // asynchronous reset mid-capture
    do_arm(0, 100, 1'b0);
    step(2'b11, 2'b00, 0);
    step(2'b11, 2'b00, 1);
    step(2'b01, 2'b00, 2);
    idle();
    chk("pre_rst_count", 64'(count), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_instret", instret, 64'd0);
    chk("arst_trap", 64'(trap_cnt), 64'd0);
    chk("arst_dropped", 64'(dropped), 64'd0);
    chk("arst_rd_data", 64'(|rd_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
